// File: rtl/spatial_encoder_sequencer.sv
// Spatial encoder sequencer: latches one frame of channel feature codes,
// then walks the channels one per cycle. For each channel it presents the
// item-memory address, the feature code and the accumulator strobes. When
// the frame is finished it holds the result valid until downstream accepts it.
module spatial_encoder_sequencer #(
    parameter int MOD0_CHANNELS = 32,
    parameter int MOD1_CHANNELS = 77,
    parameter int MOD2_CHANNELS = 108,
    parameter int CHANNEL_WIDTH = 2,
    parameter int IDX_WIDTH     = 8
) (
    input  logic                                                               Clk_CI,
    input  logic                                                               Reset_RBI,
    input  logic                                                               FrameValid_SI,
    output logic                                                               FrameReady_SO,
    input  logic [(MOD0_CHANNELS+MOD1_CHANNELS+MOD2_CHANNELS)*CHANNEL_WIDTH-1:0] FrameIn_DI,
    input  logic                                                               Stall_SI,
    output logic [IDX_WIDTH-1:0]                                               ChannelIdx_DO,
    output logic [CHANNEL_WIDTH-1:0]                                           FeatureOut_DO,
    output logic                                                               Enable_SO,
    output logic                                                               FirstHypervector_SO,
    output logic                                                               StoreSecond_SO,
    output logic                                                               XorFinal_SO,
    output logic                                                               ResultValid_SO,
    input  logic                                                               ResultReady_SI
);

    localparam int N_CHANNELS  = MOD0_CHANNELS + MOD1_CHANNELS + MOD2_CHANNELS;
    localparam int FRAME_WIDTH = N_CHANNELS * CHANNEL_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Modality boundaries, expressed as channel indices.
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO    = IDX_WIDTH'(0);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE     = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] SECOND0_IDX = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] SECOND1_IDX = IDX_WIDTH'(MOD0_CHANNELS + 1);
    localparam logic [IDX_WIDTH-1:0] SECOND2_IDX = IDX_WIDTH'(MOD0_CHANNELS + MOD1_CHANNELS + 1);
    localparam logic [IDX_WIDTH-1:0] FINAL0_IDX  = IDX_WIDTH'(MOD0_CHANNELS - 1);
    localparam logic [IDX_WIDTH-1:0] FINAL1_IDX  = IDX_WIDTH'(MOD0_CHANNELS + MOD1_CHANNELS - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(N_CHANNELS - 1);

    // A single-channel modality has no second channel; its start+1 would
    // alias the first channel of the next modality, so it must be masked.
    localparam bit HAS_SECOND0 = (MOD0_CHANNELS >= 2);
    localparam bit HAS_SECOND1 = (MOD1_CHANNELS >= 2);
    localparam bit HAS_SECOND2 = (MOD2_CHANNELS >= 2);

    logic [1:0]               r_state;
    logic [IDX_WIDTH-1:0]     r_idx;
    logic [FRAME_WIDTH-1:0]   r_frame;

    logic                     w_enable;
    logic                     w_first;
    logic                     w_second;
    logic                     w_xor_final;
    logic [CHANNEL_WIDTH-1:0] w_feature;

    // Sequencer state, channel index and latched frame.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_state <= ST_IDLE;
            r_idx   <= IDX_ZERO;
            r_frame <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (FrameValid_SI) begin
                        r_frame <= FrameIn_DI;
                        r_idx   <= IDX_ZERO;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!Stall_SI) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= IDX_ZERO;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_DONE: begin
                    if (ResultReady_SI) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= IDX_ZERO;
                end
            endcase
        end
    end

    // Accumulator strobes and feature mux, live only while stepping channels.
    always_comb begin
        w_enable    = 1'b0;
        w_first     = 1'b0;
        w_second    = 1'b0;
        w_xor_final = 1'b0;
        w_feature   = '0;
        if (r_state == ST_RUN) begin
            w_enable    = !Stall_SI;
            w_first     = (r_idx == IDX_ZERO);
            w_second    = (HAS_SECOND0 && (r_idx == SECOND0_IDX)) ||
                          (HAS_SECOND1 && (r_idx == SECOND1_IDX)) ||
                          (HAS_SECOND2 && (r_idx == SECOND2_IDX));
            w_xor_final = (r_idx == FINAL0_IDX) || (r_idx == FINAL1_IDX) ||
                          (r_idx == LAST_IDX);
            w_feature   = r_frame[int'(r_idx)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end else begin
            w_enable    = 1'b0;
            w_feature   = '0;
        end
    end

    assign FrameReady_SO       = (r_state == ST_IDLE);
    assign ResultValid_SO      = (r_state == ST_DONE);
    assign ChannelIdx_DO       = r_idx;
    assign FeatureOut_DO       = w_feature;
    assign Enable_SO           = w_enable;
    assign FirstHypervector_SO = w_first;
    assign StoreSecond_SO      = w_second;
    assign XorFinal_SO         = w_xor_final;

endmodule

// File: tb/tb_spatial_encoder_sequencer.sv
// Bench for spatial_encoder_sequencer: full-size instance driven by directed
// and randomised frames checked against a channel/modality model, plus a
// small 1/2/3-channel instance checked from a per-cycle vector table.
module tb_spatial_encoder_sequencer;

    localparam int M0 = 32;
    localparam int M1 = 77;
    localparam int M2 = 108;
    localparam int N  = M0 + M1 + M2;
    localparam int W  = 2;
    localparam int IW = 8;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- full-size DUT ----------------
    logic            rst_n;
    logic            fv;
    logic            fr;
    logic [N*W-1:0]  frame_in;
    logic            stall;
    logic [IW-1:0]   idx;
    logic [W-1:0]    feat;
    logic            en, first, second, xorf, rv, rr;

    spatial_encoder_sequencer dut (
        .Clk_CI(clk), .Reset_RBI(rst_n), .FrameValid_SI(fv), .FrameReady_SO(fr),
        .FrameIn_DI(frame_in), .Stall_SI(stall), .ChannelIdx_DO(idx),
        .FeatureOut_DO(feat), .Enable_SO(en), .FirstHypervector_SO(first),
        .StoreSecond_SO(second), .XorFinal_SO(xorf), .ResultValid_SO(rv),
        .ResultReady_SI(rr)
    );

    // ---------------- small DUT (1/2/3 channels) ----------------
    logic        s_rst_n, s_fv, s_fr, s_stall, s_en, s_first, s_second, s_xorf, s_rv, s_rr;
    logic [11:0] s_frame_in;
    logic [2:0]  s_idx;
    logic [1:0]  s_feat;

    spatial_encoder_sequencer #(
        .MOD0_CHANNELS(1), .MOD1_CHANNELS(2), .MOD2_CHANNELS(3),
        .CHANNEL_WIDTH(2), .IDX_WIDTH(3)
    ) dut_small (
        .Clk_CI(clk), .Reset_RBI(s_rst_n), .FrameValid_SI(s_fv), .FrameReady_SO(s_fr),
        .FrameIn_DI(s_frame_in), .Stall_SI(s_stall), .ChannelIdx_DO(s_idx),
        .FeatureOut_DO(s_feat), .Enable_SO(s_en), .FirstHypervector_SO(s_first),
        .StoreSecond_SO(s_second), .XorFinal_SO(s_xorf), .ResultValid_SO(s_rv),
        .ResultReady_SI(s_rr)
    );

    typedef struct {
        logic       fv, stall, rr;
        logic       e_fr;
        logic [2:0] e_idx;
        logic [1:0] e_feat;
        logic       e_en, e_first, e_second, e_xor, e_rv;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference strobes from the modality a channel belongs to.
    function automatic void ref_strobes(input int k, output bit f, output bit s, output bit x);
        int start, size;
        if (k < M0) begin
            start = 0;       size = M0;
        end else if (k < M0 + M1) begin
            start = M0;      size = M1;
        end else begin
            start = M0 + M1; size = M2;
        end
        f = (k == 0);
        s = ((k - start) == 1);
        x = ((k - start) == size - 1);
    endfunction

    task automatic chk_quiet(input string nm);
        chk({nm, " en"},     32'(en), 32'd0);
        chk({nm, " first"},  32'(first), 32'd0);
        chk({nm, " second"}, 32'(second), 32'd0);
        chk({nm, " xor"},    32'(xorf), 32'd0);
        chk({nm, " feat"},   32'(feat), 32'd0);
    endtask

    // Runs one frame from IDLE through DONE; called at posedge+1.
    // stall_mode: 0 none, 1 five-cycle stalls at idx 0/31/216, 2 random.
    task automatic run_frame(input logic [N*W-1:0] frame, input int stall_mode,
                             input logic rr_run, input int hold, output int run_cycles);
        int  k = 0;
        int  stalled_here = 0;
        bit  s, ef, es, ex;
        fv = 1'b1; frame_in = frame; rr = rr_run; stall = 1'b0;
        @(negedge clk);
        chk("idle ready", 32'(fr), 32'd1);
        chk("idle rv", 32'(rv), 32'd0);
        chk_quiet("idle");
        @(posedge clk); #1;
        fv = 1'b0;
        frame_in = '0;  // the latched copy must be used from here on
        run_cycles = 0;
        for (int cyc = 0; cyc < 3000 && k < N; cyc++) begin
            case (stall_mode)
                1: s = ((k == 0) || (k == 31) || (k == N - 1)) && (stalled_here < 5);
                2: s = ($urandom_range(0, 3) == 0);
                default: s = 1'b0;
            endcase
            stall = s;
            @(negedge clk);
            ref_strobes(k, ef, es, ex);
            chk("run idx",    32'(idx), 32'(k));
            chk("run en",     32'(en), 32'(!s));
            chk("run first",  32'(first), 32'(ef));
            chk("run second", 32'(second), 32'(es));
            chk("run xor",    32'(xorf), 32'(ex));
            chk("run feat",   32'(feat), 32'(frame[k*W +: W]));
            chk("run ready",  32'(fr), 32'd0);
            chk("run rv",     32'(rv), 32'd0);
            run_cycles++;
            @(posedge clk); #1;
            if (!s) begin
                k++;
                stalled_here = 0;
            end else begin
                stalled_here++;
            end
        end
        stall = 1'b0;
        if (k != N) begin
            n_checks++; n_fail++;
            $display("FAIL run timeout: reached channel %0d expected %0d", k, N);
        end
        for (int h = 0; h < hold; h++) begin
            fv = 1'b1; rr = 1'b0;
            @(negedge clk);
            chk("done hold rv", 32'(rv), 32'd1);
            chk("done hold ready", 32'(fr), 32'd0);
            chk_quiet("done hold");
            @(posedge clk); #1;
        end
        rr = 1'b1;
        @(negedge clk);
        chk("done rv", 32'(rv), 32'd1);
        chk("done ready", 32'(fr), 32'd0);
        chk("done en", 32'(en), 32'd0);
        @(posedge clk); #1;
        rr = 1'b0; fv = 1'b0;
        @(negedge clk);
        chk("post done rv", 32'(rv), 32'd0);
        chk("post done ready", 32'(fr), 32'd1);
        chk("post done en", 32'(en), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [N*W-1:0] f;
    int             rc;

    initial begin
        rst_n = 1'b0; fv = 1'b0; frame_in = '0; stall = 1'b0; rr = 1'b0;
        s_rst_n = 1'b0; s_fv = 1'b0; s_frame_in = 12'h000; s_stall = 1'b0; s_rr = 1'b0;

        // Small-instance vectors: one row per cycle, channel c carries (c+1) mod 4.
        //           fv    st    rr    fr    idx   feat  en    1st   2nd   xor   rv
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state while reset is still asserted.
        chk("reset ready", 32'(fr), 32'd1);
        chk("reset idx", 32'(idx), 32'd0);
        chk("reset rv", 32'(rv), 32'd0);
        chk_quiet("reset");
        rst_n = 1'b1; s_rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 6: small instance, table-driven.
        s_frame_in = 12'h939;
        for (int i = 0; i < 11; i++) begin
            s_fv = vecs[i].fv; s_stall = vecs[i].stall; s_rr = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("small[%0d] ready", i),  32'(s_fr),     32'(vecs[i].e_fr));
            chk($sformatf("small[%0d] idx", i),    32'(s_idx),    32'(vecs[i].e_idx));
            chk($sformatf("small[%0d] feat", i),   32'(s_feat),   32'(vecs[i].e_feat));
            chk($sformatf("small[%0d] en", i),     32'(s_en),     32'(vecs[i].e_en));
            chk($sformatf("small[%0d] first", i),  32'(s_first),  32'(vecs[i].e_first));
            chk($sformatf("small[%0d] second", i), 32'(s_second), 32'(vecs[i].e_second));
            chk($sformatf("small[%0d] xor", i),    32'(s_xorf),   32'(vecs[i].e_xor));
            chk($sformatf("small[%0d] rv", i),     32'(s_rv),     32'(vecs[i].e_rv));
            @(posedge clk); #1;
        end
        s_fv = 1'b0; s_stall = 1'b0; s_rr = 1'b0;

        // Test 1: all features 1, no stall, ResultReady held high.
        for (int c = 0; c < N; c++) f[c*W +: W] = 2'd1;
        run_frame(f, 0, 1'b1, 0, rc);
        chk("t1 run cycles", 32'(rc), 32'(N));

        // Test 2: feature = c mod 4.
        for (int c = 0; c < N; c++) f[c*W +: W] = 2'(c % 4);
        run_frame(f, 0, 1'b0, 0, rc);
        chk("t2 run cycles", 32'(rc), 32'(N));

        // Test 3: five-cycle stalls at idx 0, 31, 216.
        run_frame(f, 1, 1'b0, 0, rc);
        chk("t3 run cycles", 32'(rc), 32'(N + 15));

        // Test 4: ResultReady held low 10 cycles in DONE with FrameValid high.
        for (int c = 0; c < N; c++) f[c*W +: W] = 2'(3 - (c % 4));
        run_frame(f, 0, 1'b0, 10, rc);
        chk("t4 run cycles", 32'(rc), 32'(N));

        // Test 5: reset asserted while at idx 100.
        fv = 1'b1; frame_in = f;
        @(posedge clk); #1;
        fv = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t5 pre-reset idx", 32'(idx), 32'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async ready", 32'(fr), 32'd1);
        chk("t5 async idx", 32'(idx), 32'd0);
        chk("t5 async rv", 32'(rv), 32'd0);
        chk_quiet("t5 async");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(f, 0, 1'b0, 0, rc);
        chk("t5 restart run cycles", 32'(rc), 32'(N));

        // Randomised frames, stalls and DONE hold lengths.
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < N; c++) f[c*W +: W] = 2'($urandom_range(0, 3));
            run_frame(f, 2, 1'($urandom_range(0, 1)), $urandom_range(0, 4), rc);
            if (rc < N) begin
                n_checks++; n_fail++;
                $display("FAIL rand run cycles: got %0d expected at least %0d", rc, N);
            end else begin
                n_checks++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
